// File: rtl/tlm_batch_streamer.sv
// tlm_batch_streamer
//   Collects up to DEPTH {op, A, B} items from the load port. On batch_go_i it
//   issues them one at a time to a start/done BFM. Each result, or 0 when the
//   BFM does not answer within TIMEOUT cycles, is returned on a valid/ready
//   result port.
//
// Ports
//   clk_i, reset_i                 clock, asynchronous active-low reset
//   load_valid_i/load_ready_o      load handshake, payload load_op_i/load_a_i/load_b_i
//   batch_go_i                     pulse: run the loaded batch
//   busy_o                         high while a batch is executing
//   op_o/a_o/b_o, start_o          BFM request; start_o is a one-cycle pulse
//   done_i, res_i                  BFM completion and result
//   res_valid_o/res_ready_i        result handshake, payload res_data_o
//   item_cnt_o                     number of items currently loaded
//   batch_done_o                   one-cycle pulse at the end of a batch
//   timeout_o                      sticky: an item in this batch timed out
//
// Configuration macro
//   STREAMER_ERR_TAG_EN            adds res_err_o, which is high with res_valid_o
//                                  when the item timed out
module tlm_batch_streamer #(
  parameter int DEPTH      = 100,
  parameter int ITEM_WIDTH = 8,
  parameter int OP_WIDTH   = 3,
  parameter int RES_WIDTH  = 16,
  parameter int TIMEOUT    = 255,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [OP_WIDTH-1:0]   load_op_i,
  input  logic [ITEM_WIDTH-1:0] load_a_i,
  input  logic [ITEM_WIDTH-1:0] load_b_i,
  input  logic                  batch_go_i,
  output logic                  busy_o,
  output logic [OP_WIDTH-1:0]   op_o,
  output logic [ITEM_WIDTH-1:0] a_o,
  output logic [ITEM_WIDTH-1:0] b_o,
  output logic                  start_o,
  input  logic                  done_i,
  input  logic [RES_WIDTH-1:0]  res_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [RES_WIDTH-1:0]  res_data_o,
  output logic [CNT_W-1:0]      item_cnt_o,
  output logic                  batch_done_o,
`ifdef STREAMER_ERR_TAG_EN
  output logic                  res_err_o,
`endif
  output logic                  timeout_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ITEM_W = OP_WIDTH + 2 * ITEM_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_FINISH} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    count;
  logic [IDX_W-1:0]    idx;
  logic [TMR_W-1:0]    timer;
  logic [ITEM_W-1:0]   item_mem [DEPTH];
  logic [ITEM_W-1:0]   cur_item;
  logic [RES_WIDTH-1:0] res_q;
  logic                timeout_q;
  logic                err_q;
  logic                empty_done;
  logic                load_fire, go_fire, go_empty, last_item;

  // Ready is gated by reset_i directly so it reads 0 while reset is held and
  // rises as soon as reset is released.
  assign load_ready_o = reset_i && (state == S_IDLE) && (count < DEPTH_C);
  assign load_fire    = load_valid_i && load_ready_o;
  // A load in the same cycle as go joins the batch, so it counts as non-empty.
  assign go_fire      = (state == S_IDLE) && batch_go_i && ((count != '0) || load_fire);
  assign go_empty     = (state == S_IDLE) && batch_go_i && (count == '0) && !load_fire;
  assign last_item    = ((CNT_W'(idx) + CNT_W'(1)) == count);

  assign cur_item = item_mem[idx];
  assign {op_o, a_o, b_o} = ((state == S_ISSUE) || (state == S_WAIT)) ? cur_item : '0;

  assign busy_o       = (state != S_IDLE);
  assign start_o      = (state == S_ISSUE);
  assign res_valid_o  = (state == S_EMIT);
  assign res_data_o   = res_q;
  assign item_cnt_o   = count;
  assign timeout_o    = timeout_q;
  // An empty go never leaves IDLE; its completion pulse comes from a flag.
  assign batch_done_o = (state == S_FINISH) || empty_done;
`ifdef STREAMER_ERR_TAG_EN
  assign res_err_o    = err_q;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (go_fire) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (done_i || (timer == TMR_LAST)) state_nxt = S_EMIT;
      S_EMIT:   if (res_ready_i) state_nxt = last_item ? S_FINISH : S_ISSUE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count      <= '0;
      idx        <= '0;
      timer      <= '0;
      res_q      <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      empty_done <= 1'b0;
    end else begin
      empty_done <= go_empty;
      unique case (state)
        S_IDLE: begin
          if (load_fire) count <= count + CNT_W'(1);
          if (go_fire) begin
            idx       <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          if (done_i) begin
            res_q <= res_i;
            err_q <= 1'b0;
          end else if (timer == TMR_LAST) begin
            res_q     <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_EMIT:   if (res_ready_i && !last_item) idx <= idx + IDX_W'(1);
        S_FINISH: count <= '0;
        default: ;
      endcase
    end
  end

  // Item storage carries no reset; only slots below count are ever read.
  always_ff @(posedge clk_i) begin
    if (load_fire) item_mem[count[IDX_W-1:0]] <= {load_op_i, load_a_i, load_b_i};
  end

endmodule
